// File: rtl/alu_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer_pkg
//  Shared definitions for the ALU_Pro command sequencer: FSM state encoding,
//  default widths and the ALU_Pro opcode names.
// ---------------------------------------------------------------------------
package alu_cmd_sequencer_pkg;

    localparam int DW_DEFAULT  = 16;
    localparam int OPW_DEFAULT = 3;

    // ALU_Pro opcode names (meaning is owned by ALU_Pro itself)
    localparam logic [2:0] OP_0 = 3'd0;
    localparam logic [2:0] OP_1 = 3'd1;
    localparam logic [2:0] OP_2 = 3'd2;
    localparam logic [2:0] OP_3 = 3'd3;
    localparam logic [2:0] OP_4 = 3'd4;
    localparam logic [2:0] OP_5 = 3'd5;
    localparam logic [2:0] OP_6 = 3'd6;
    localparam logic [2:0] OP_7 = 3'd7;

    // Encoding 2'd3 is unused; the FSM recovers from it to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//  Initiator side of the ALU_Pro operand interface. Accepts one command at a
//  time over valid/ready, presents the operands to a combinational ALU_Pro
//  with alu_en high for SETTLE_CYC cycles, captures the result and returns it
//  with the command tag over valid/ready.
//
//  Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_a, cmd_b, cmd_op, cmd_tag
//   alu_a/alu_b/alu_op/alu_en  registered drive into ALU_Pro
//   alu_result               combinational result from ALU_Pro
//   res_valid/res_ready      result handshake; res_data, res_tag
//   busy                     sequencer is not idle
//   op_count                 completed result handshakes, 16-bit wrapping
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DW         = 16,
    parameter int OPW        = 3,
    parameter int TAGW       = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [DW-1:0]   cmd_a,
    input  logic [DW-1:0]   cmd_b,
    input  logic [OPW-1:0]  cmd_op,
    input  logic [TAGW-1:0] cmd_tag,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [OPW-1:0]  alu_op,
    output logic            alu_en,
    input  logic [DW-1:0]   alu_result,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [DW-1:0]   res_data,
    output logic [TAGW-1:0] res_tag,
    output logic            busy,
    output logic [15:0]     op_count
);

    localparam int CW = $clog2(SETTLE_CYC) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("alu_cmd_sequencer: SETTLE_CYC must be at least 1");
    end

    seq_state_e      state_r;
    seq_state_e      state_nx_s;
    logic [CW-1:0]   cnt_r;
    logic [TAGW-1:0] tag_r;
    logic [DW-1:0]   alu_a_r;
    logic [DW-1:0]   alu_b_r;
    logic [OPW-1:0]  alu_op_r;
    logic            alu_en_r;
    logic [DW-1:0]   res_data_r;
    logic [TAGW-1:0] res_tag_r;
    logic            res_valid_r;
    logic [15:0]     op_count_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; illegal encodings fall back to idle
    always_comb begin
        state_nx_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nx_s = S_DRIVE;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = S_HOLD;
                end else begin
                    state_nx_s = S_DRIVE;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_HOLD;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch, settle counter, result capture, completion count
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            alu_op_r    <= '0;
            alu_en_r    <= 1'b0;
            cnt_r       <= '0;
            tag_r       <= '0;
            res_data_r  <= '0;
            res_tag_r   <= '0;
            res_valid_r <= 1'b0;
            op_count_r  <= 16'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    // cmd_ready is 1 here, so cmd_valid alone completes the handshake
                    if (cmd_valid) begin
                        alu_a_r  <= cmd_a;
                        alu_b_r  <= cmd_b;
                        alu_op_r <= cmd_op;
                        tag_r    <= cmd_tag;
                        cnt_r    <= '0;
                        alu_en_r <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    cnt_r <= cnt_r + CW'(1);
                    // alu_en is still high on this edge, so alu_result is the live value
                    if (cnt_r == CNT_LAST) begin
                        res_data_r  <= alu_result;
                        res_tag_r   <= tag_r;
                        res_valid_r <= 1'b1;
                        alu_en_r    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        op_count_r  <= op_count_r + 16'd1;
                    end
                end
                default: begin
                    alu_en_r    <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Handshake flags decode only the state register, never res_ready
    assign cmd_ready = (state_r == S_IDLE);
    assign busy      = (state_r != S_IDLE);

    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign alu_en    = alu_en_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_tag   = res_tag_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//  Self-checking bench for alu_cmd_sequencer with a stub ALU
//  (result = en ? (op==0 ? a+b : a^b) : 0). A main instance uses
//  SETTLE_CYC=1 with a scoreboard/monitor; a second instance uses
//  SETTLE_CYC=3 for the longer settle window.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int S = 1;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = 16'd0;
    logic [15:0] cmd_b = 16'd0;
    logic [2:0]  cmd_op = 3'd0;
    logic [3:0]  cmd_tag = 4'd0;
    logic [15:0] alu_a, alu_b, alu_result, res_data;
    logic [2:0]  alu_op;
    logic        alu_en, res_valid, busy;
    logic        res_ready = 1'b1;
    logic [3:0]  res_tag;
    logic [15:0] op_count;

    logic        cmd3_valid = 1'b0;
    logic        cmd3_ready;
    logic [15:0] cmd3_a = 16'd0;
    logic [15:0] cmd3_b = 16'd0;
    logic [2:0]  cmd3_op = 3'd0;
    logic [3:0]  cmd3_tag = 4'd0;
    logic [15:0] alu3_a, alu3_b, alu3_result, res3_data;
    logic [2:0]  alu3_op;
    logic        alu3_en, res3_valid, busy3;
    logic        res3_ready = 1'b1;
    logic [3:0]  res3_tag;
    logic [15:0] op3_count;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   rr_mode = 0;
    exp_t sb[$];

    int          exp_count = 0;
    int          en_run = 0;
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [15:0] prev_data = 16'd0;
    logic [3:0]  prev_tag = 4'd0;

    assign alu_result  = alu_en  ? ((alu_op  == 3'd0) ? alu_a  + alu_b  : alu_a  ^ alu_b)  : 16'd0;
    assign alu3_result = alu3_en ? ((alu3_op == 3'd0) ? alu3_a + alu3_b : alu3_a ^ alu3_b) : 16'd0;

    alu_cmd_sequencer #(.DW(16), .OPW(3), .TAGW(4), .SETTLE_CYC(S)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
        .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag),
        .busy(busy), .op_count(op_count)
    );

    alu_cmd_sequencer #(.DW(16), .OPW(3), .TAGW(4), .SETTLE_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready),
        .cmd_a(cmd3_a), .cmd_b(cmd3_b), .cmd_op(cmd3_op), .cmd_tag(cmd3_tag),
        .alu_a(alu3_a), .alu_b(alu3_b), .alu_op(alu3_op), .alu_en(alu3_en),
        .alu_result(alu3_result),
        .res_valid(res3_valid), .res_ready(res3_ready),
        .res_data(res3_data), .res_tag(res3_tag),
        .busy(busy3), .op_count(op3_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference result of the stub ALU for one command
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
        if (op == 3'd0) return a + b;
        return a ^ b;
    endfunction

    // Consumer backpressure: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clk) begin
        #1;
        if (rr_mode == 0)      res_ready = 1'b1;
        else if (rr_mode == 2) res_ready = 1'b0;
        else                   res_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: protocol checks and scoreboard pop on every result handshake
    always @(negedge clk) begin
        if (rst) begin
            exp_count  = 0;
            en_run     = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            chk("op_count", op_count, exp_count[15:0]);
            if (alu_en) begin
                en_run++;
            end else if (en_run != 0) begin
                chk("alu_en_len", en_run, S);
                en_run = 0;
            end
            if (res_valid) chk("cmd_ready_in_hold", cmd_ready, 0);
            if (prev_valid && !prev_hs) begin
                chk("valid_held", res_valid, 1);
                chk("data_held", res_data, prev_data);
                chk("tag_held", res_tag, prev_tag);
            end
            if (res_valid && !prev_valid) begin
                chk("result_expected", sb.size() != 0, 1);
                if (sb.size() != 0) chk("latency", cyc, sb[0].acc + S);
            end
            if (res_valid && res_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_tag", res_tag, e.tag);
                exp_count = (exp_count + 1) % 65536;
            end
            prev_valid = res_valid;
            prev_hs    = res_valid && res_ready;
            prev_data  = res_data;
            prev_tag   = res_tag;
        end
    end

    // Offer a command; while the sequencer is busy, drive junk (sometimes valid)
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [3:0] tag);
        int  n;
        bit  got;
        exp_t e;
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (cmd_ready && !rst) begin
                cmd_valid = 1'b1;
                cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
                e.data = model(a, b, op);
                e.tag  = tag;
                e.acc  = cyc + 1;
                sb.push_back(e);
                got = 1'b1;
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_a   = 16'($urandom);
                cmd_b   = 16'($urandom);
                cmd_op  = 3'($urandom);
                cmd_tag = 4'($urandom);
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || res_valid) && n < 200);
        if (n >= 200) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int   n3;
        int   en_cnt;
        int   lat;
        bit   got;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_res_data", res_data, 0);

        // Basic command
        rr_mode = 0;
        send(16'd4, 16'd8, 3'd0, 4'd3);
        wait_idle();
        chk("basic_op_count", op_count, 1);

        // Backpressure: consumer stalls 5 cycles while a second command waits
        rr_mode = 2;
        send(16'h1234, 16'h00FF, 3'd1, 4'd7);
        fork
            send(16'hFFFF, 16'd2, 3'd0, 4'd9);
            begin
                repeat (6) @(negedge clk);
                chk("bp_still_valid", res_valid, 1);
                rr_mode = 0;
            end
        join
        wait_idle();

        // Randomized commands with random backpressure
        rr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send(16'($urandom), 16'($urandom), 3'($urandom), 4'($urandom));
        end
        rr_mode = 0;
        wait_idle();

        // Reset while the command is being driven: the result is dropped
        send(16'd100, 16'd200, 3'd0, 4'd1);
        @(negedge clk);
        chk("mid_drive_en", alu_en, 1);
        #1 rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_alu_en", alu_en, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_op_count", op_count, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        repeat (10) @(negedge clk);

        // op_count wrap via preload
        @(negedge clk);
        u_dut.op_count_r = 16'hFFFF;
        exp_count = 65535;
        send(16'd1, 16'd1, 3'd0, 4'd2);
        wait_idle();
        chk("wrap_zero", op_count, 16'h0000);
        send(16'd5, 16'd3, 3'd2, 4'd4);
        wait_idle();
        chk("wrap_one", op_count, 16'h0001);

        // SETTLE_CYC=3 instance: a=4, b=8, op=1
        @(negedge clk);
        chk("s3_cmd_ready", cmd3_ready, 1);
        n3 = cyc;
        cmd3_valid = 1'b1;
        cmd3_a = 16'd4; cmd3_b = 16'd8; cmd3_op = 3'd1; cmd3_tag = 4'd5;
        @(posedge clk);
        #1 cmd3_valid = 1'b0;
        en_cnt = 0;
        lat    = 0;
        got    = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (alu3_en) en_cnt++;
            if (res3_valid) begin
                got = 1'b1;
                lat = cyc - (n3 + 1);
                chk("s3_res_data", res3_data, 16'h000C);
                chk("s3_res_tag", res3_tag, 4'd5);
            end
        end
        chk("s3_result_seen", got, 1);
        chk("s3_alu_en_cycles", en_cnt, 3);
        chk("s3_latency", lat, 3);
        repeat (2) @(negedge clk);
        chk("s3_op_count", op3_count, 1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
